// File: rtl/wbq_pkg.sv
// Shared types for the writeback queue: register-file widths and the queue entry layout.
package wbq_pkg;
  localparam int DEST_W = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// Dual-push / single-pop circular buffer; push0 is older than push1 when both fire.
// Writes are visible next cycle; the caller guarantees free space and never pops when empty.
module wbq_fifo
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push0_vld,
  input  wbq_entry_t             i_push0_dat,
  input  logic                   i_push1_vld,
  input  wbq_entry_t             i_push1_dat,
  input  logic                   i_pop,
  output logic [CW-1:0]          o_count,
  output logic [PW-1:0]          o_rd_ptr,
  output wbq_entry_t             o_head,
  output wbq_entry_t [DEPTH-1:0] o_entries,
  output logic [DEPTH-1:0]       o_valid
);
  wbq_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]       r_valid;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          w_wr_ptr1;
  logic [CW:0]            w_count_next;

  assign w_wr_ptr1    = r_wr_ptr + PW'(1);
  assign w_count_next = (CW+1)'(r_count) + (CW+1)'(i_push0_vld) + (CW+1)'(i_push1_vld)
                      - (CW+1)'(i_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem    <= '0;
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      if (i_push0_vld) begin
        r_mem[r_wr_ptr]   <= i_push0_dat;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (i_push1_vld) begin
        r_mem[w_wr_ptr1]   <= i_push1_dat;
        r_valid[w_wr_ptr1] <= 1'b1;
      end
      r_wr_ptr <= r_wr_ptr + PW'(i_push0_vld) + PW'(i_push1_vld);
      r_count  <= w_count_next[CW-1:0];
    end
  end

  // An underflow wraps w_count_next to a large value, so one bound covers both directions.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_count_next <= (CW+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(i_pop && (r_count == '0)));

  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign o_valid   = r_valid;
endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue merging load and ALU results, retiring one write per cycle (accept->write 2 cycles).
// Readiness uses the registered count only; WBQ_FWD_EN adds youngest-match forwarding ports.
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [DEST_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [DEST_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic [DEST_W-1:0] hz_src1,
  input  logic [DEST_W-1:0] hz_src2,
  output logic              hz_hit,
`ifdef WBQ_FWD_EN
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic              writeBackEn,
  output logic [DEST_W-1:0] Dest_wb,
  output logic [DATA_W-1:0] Result_WB
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]          w_count;
  logic [PW-1:0]          w_rd_ptr;
  wbq_entry_t             w_head;
  wbq_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]       w_valid;
  logic                   w_mem_push, w_alu_push, w_pop;
  logic                   w_push0_vld, w_push1_vld;
  wbq_entry_t             w_mem_ent, w_alu_ent, w_push0_dat;
  logic                   r_wb_en;
  wbq_entry_t             r_wb;
  logic                   w_hit1, w_hit2;
  logic [PW-1:0]          w_idx;
`ifdef WBQ_FWD_EN
  logic [DATA_W-1:0]      w_fdat1, w_fdat2;
`endif

  // A load with a pending ALU result claims the slot first, so the ALU needs two free entries.
  assign mem_ready = (w_count < CW'(DEPTH));
  assign alu_ready = mem_valid ? (w_count <= CW'(DEPTH - 2)) : mem_ready;

  assign w_mem_push  = mem_valid & mem_ready;
  assign w_alu_push  = alu_valid & alu_ready;
  assign w_pop       = (w_count != '0);
  assign w_mem_ent   = '{dest: mem_dest, data: mem_data};
  assign w_alu_ent   = '{dest: alu_dest, data: alu_data};
  assign w_push0_vld = w_mem_push | w_alu_push;
  assign w_push0_dat = w_mem_push ? w_mem_ent : w_alu_ent;
  assign w_push1_vld = w_mem_push & w_alu_push;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push0_vld (w_push0_vld),
    .i_push0_dat (w_push0_dat),
    .i_push1_vld (w_push1_vld),
    .i_push1_dat (w_alu_ent),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_rd_ptr    (w_rd_ptr),
    .o_head      (w_head),
    .o_entries   (w_entries),
    .o_valid     (w_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en <= 1'b0;
      r_wb    <= '0;
    end else begin
      r_wb_en <= w_pop;
      if (w_pop) r_wb <= w_head;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest value for that register.
  always_comb begin
    w_hit1 = r_wb_en && (r_wb.dest == hz_src1);
    w_hit2 = r_wb_en && (r_wb.dest == hz_src2);
`ifdef WBQ_FWD_EN
    w_fdat1 = w_hit1 ? r_wb.data : '0;
    w_fdat2 = w_hit2 ? r_wb.data : '0;
`endif
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PW'(k);
      if (w_valid[w_idx] && (w_entries[w_idx].dest == hz_src1)) begin
        w_hit1 = 1'b1;
`ifdef WBQ_FWD_EN
        w_fdat1 = w_entries[w_idx].data;
`endif
      end
      if (w_valid[w_idx] && (w_entries[w_idx].dest == hz_src2)) begin
        w_hit2 = 1'b1;
`ifdef WBQ_FWD_EN
        w_fdat2 = w_entries[w_idx].data;
`endif
      end
    end
  end

`ifdef WBQ_FWD_EN
  assign fwd1_hit  = w_hit1;
  assign fwd2_hit  = w_hit2;
  assign fwd1_data = w_fdat1;
  assign fwd2_data = w_fdat2;
  assign hz_hit    = 1'b0;
`else
  assign hz_hit    = w_hit1 | w_hit2;
`endif

  assign writeBackEn = r_wb_en;
  assign Dest_wb     = r_wb.dest;
  assign Result_WB   = r_wb.data;
endmodule
